// File: rtl/execute_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forward selects, FSM
// states and the per-stage shadow tag carried alongside the pipeline.
package execute_hazard_ctrl_pkg;

  localparam int TAG_AW = 8;
  localparam logic [TAG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    VBUSY      = 2'd2
  } hctl_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              we;
    logic              vec;
    logic              load;
  } stage_tag_t;

  // Youngest producer wins: EX result beats the older MEM result.
  function automatic fwd_sel_e fwd_pick(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/execute_hazard_ctrl_if.sv
// Decode-to-hazard-unit bundle: ID instruction info and flush in, pipe control
// and forward selects out.
interface execute_hazard_ctrl_if #(
  parameter int REG_AW = 4
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use1;
  logic              id_use2;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_vec;
  logic              id_load;
  logic              id_multi;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic              ex_hold;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        fwdv_a;
  logic [1:0]        fwdv_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we, id_vec,
           id_load, id_multi, flush,
    input  stall, bubble, ex_hold, fwd_a, fwd_b, fwdv_a, fwdv_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we, id_vec,
           id_load, id_multi, flush,
    output stall, bubble, ex_hold, fwd_a, fwd_b, fwdv_a, fwdv_b
  );
endinterface

// File: rtl/execute_hazard_ctrl_match.sv
// Compares one ID source operand against one stage tag; scalar r0 never matches,
// vector addresses compare on the low VREG_AW bits only.
module execute_hazard_ctrl_match
  import execute_hazard_ctrl_pkg::*;
#(
  parameter int VREG_AW = 3
) (
  input  logic              tag_valid,
  input  logic              tag_we,
  input  logic              tag_vec,
  input  logic [TAG_AW-1:0] tag_rd,
  input  logic [TAG_AW-1:0] src,
  input  logic              src_use,
  input  logic              src_vec,
  output logic              hit
);
  logic addr_eq;

  always_comb begin
    addr_eq = 1'b0;
    if (src_vec) addr_eq = (tag_rd[VREG_AW-1:0] == src[VREG_AW-1:0]);
    else         addr_eq = (tag_rd == src) && (tag_rd != REG_ZERO);
  end

  assign hit = tag_valid & tag_we & (tag_vec == src_vec) & src_use & addr_eq;
endmodule

// File: rtl/execute_hazard_ctrl.sv
// Execute-stage hazard controller: registered operand-forward selects, load-use
// stall and multi-cycle vector-op hold of the ID/EX register.
//
// state      | meaning
// IDLE       | normal issue; load-use and multi-op entry evaluated
// LOAD_STALL | bubble sent behind a load last cycle; stalled instr re-issues
// VBUSY      | multi-cycle vector op owns EX; ID/EX held, front end stalled
module execute_hazard_ctrl
  import execute_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int VREG_AW    = 3,
  parameter int VOP_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  execute_hazard_ctrl_if.slave hif
);
  localparam int CW = $clog2(VOP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(VOP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  hctl_state_e       state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              kill_pend, kill_pend_nxt;
  stage_tag_t        ex_tag, mem_tag, id_tag;
  logic [TAG_AW-1:0] rs1, rs2, rd;
  logic              id_live, load_use, issue;
  logic              stall, bubble, ex_hold;
  logic              hit_ex1, hit_ex2, hit_mem1, hit_mem2;
  fwd_sel_e          fwd_a_q, fwd_b_q, fwdv_a_q, fwdv_b_q;
  logic              unused_mem_load;

  assign rs1 = {{(TAG_AW-REG_AW){1'b0}}, hif.id_rs1};
  assign rs2 = {{(TAG_AW-REG_AW){1'b0}}, hif.id_rs2};
  assign rd  = {{(TAG_AW-REG_AW){1'b0}}, hif.id_rd};

  assign id_tag = '{valid: 1'b1, rd: rd, we: hif.id_we, vec: hif.id_vec, load: hif.id_load};
  assign unused_mem_load = mem_tag.load;

  // A flushed ID instruction, or one killed while EX was busy, must never issue.
  assign id_live = hif.id_valid & ~hif.flush & ~kill_pend;

  execute_hazard_ctrl_match #(.VREG_AW(VREG_AW)) u_match_ex1 (
    .tag_valid(ex_tag.valid), .tag_we(ex_tag.we), .tag_vec(ex_tag.vec), .tag_rd(ex_tag.rd),
    .src(rs1), .src_use(hif.id_use1), .src_vec(hif.id_vec), .hit(hit_ex1)
  );
  execute_hazard_ctrl_match #(.VREG_AW(VREG_AW)) u_match_ex2 (
    .tag_valid(ex_tag.valid), .tag_we(ex_tag.we), .tag_vec(ex_tag.vec), .tag_rd(ex_tag.rd),
    .src(rs2), .src_use(hif.id_use2), .src_vec(hif.id_vec), .hit(hit_ex2)
  );
  execute_hazard_ctrl_match #(.VREG_AW(VREG_AW)) u_match_mem1 (
    .tag_valid(mem_tag.valid), .tag_we(mem_tag.we), .tag_vec(mem_tag.vec), .tag_rd(mem_tag.rd),
    .src(rs1), .src_use(hif.id_use1), .src_vec(hif.id_vec), .hit(hit_mem1)
  );
  execute_hazard_ctrl_match #(.VREG_AW(VREG_AW)) u_match_mem2 (
    .tag_valid(mem_tag.valid), .tag_we(mem_tag.we), .tag_vec(mem_tag.vec), .tag_rd(mem_tag.rd),
    .src(rs2), .src_use(hif.id_use2), .src_vec(hif.id_vec), .hit(hit_mem2)
  );

  assign load_use = id_live & ex_tag.load & (hit_ex1 | hit_ex2);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    kill_pend_nxt = kill_pend;
    stall         = 1'b0;
    bubble        = 1'b0;
    ex_hold       = 1'b0;
    case (state)
      VBUSY: begin
        stall   = 1'b1;
        ex_hold = 1'b1;
        cnt_nxt = cnt - CNT_ONE;
        // The held op is older than the branch; remember the kill for later.
        if (hif.flush) kill_pend_nxt = 1'b1;
        if (cnt == CNT_ONE) state_nxt = IDLE;
      end
      default: begin
        kill_pend_nxt = 1'b0;
        state_nxt     = IDLE;
        if (hif.flush || kill_pend) begin
          bubble = 1'b1;
        end else if (load_use) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          state_nxt = LOAD_STALL;
        end else if (id_live && hif.id_multi) begin
          state_nxt = VBUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
    endcase
  end

  assign issue = ~ex_hold & ~bubble & id_live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      kill_pend <= 1'b0;
      ex_tag    <= '0;
      mem_tag   <= '0;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      fwdv_a_q  <= FWD_RF;
      fwdv_b_q  <= FWD_RF;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      kill_pend <= kill_pend_nxt;
      if (ex_hold) begin
        mem_tag <= '0;
      end else begin
        mem_tag  <= ex_tag;
        ex_tag   <= issue ? id_tag : '0;
        fwd_a_q  <= (issue && !hif.id_vec) ? fwd_pick(hit_ex1, hit_mem1) : FWD_RF;
        fwd_b_q  <= (issue && !hif.id_vec) ? fwd_pick(hit_ex2, hit_mem2) : FWD_RF;
        fwdv_a_q <= (issue &&  hif.id_vec) ? fwd_pick(hit_ex1, hit_mem1) : FWD_RF;
        fwdv_b_q <= (issue &&  hif.id_vec) ? fwd_pick(hit_ex2, hit_mem2) : FWD_RF;
      end
    end
  end

  assign hif.stall   = stall;
  assign hif.bubble  = bubble;
  assign hif.ex_hold = ex_hold;
  assign hif.fwd_a   = fwd_a_q;
  assign hif.fwd_b   = fwd_b_q;
  assign hif.fwdv_a  = fwdv_a_q;
  assign hif.fwdv_b  = fwdv_b_q;
endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// Bench for execute_hazard_ctrl: pipeline-level reference model checked every
// cycle plus directed scenarios with literal expectations.
module tb_execute_hazard_ctrl;
  localparam int REG_AW     = 4;
  localparam int VREG_AW    = 3;
  localparam int VOP_CYCLES = 4;
  localparam int VMOD       = 1 << VREG_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  execute_hazard_ctrl_if #(.REG_AW(REG_AW)) hif ();

  execute_hazard_ctrl #(
    .REG_AW(REG_AW), .VREG_AW(VREG_AW), .VOP_CYCLES(VOP_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  // Reference model: what sits in EX and MEM, how many hold cycles remain.
  typedef struct packed {
    bit       v;
    bit [7:0] rd;
    bit       we;
    bit       vec;
    bit       ld;
  } slot_t;

  slot_t    m_ex, m_mem;
  int       m_busy;
  bit       m_kill;
  bit [1:0] m_fa, m_fb, m_fva, m_fvb;

  function automatic bit hits(slot_t s, int a, bit u, bit vec);
    if (!(s.v && s.we && u && (s.vec == vec))) return 1'b0;
    if (vec) return (int'(s.rd) % VMOD) == (a % VMOD);
    return (int'(s.rd) == a) && (a != 0);
  endfunction

  function automatic bit [1:0] pick(bit in_ex, bit in_mem);
    if (in_ex)  return 2'd1;
    if (in_mem) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    bit        live, es, eb, eh, iss, vec;
    int        a1, a2;
    logic [10:0] got, exp;
    slot_t     cur;
    got = {hif.stall, hif.bubble, hif.ex_hold, hif.fwd_a, hif.fwd_b, hif.fwdv_a, hif.fwdv_b};
    if (rst) begin
      m_ex = '0; m_mem = '0; m_busy = 0; m_kill = 1'b0;
      m_fa = 2'd0; m_fb = 2'd0; m_fva = 2'd0; m_fvb = 2'd0;
      exp = '0;
    end else begin
      vec  = hif.id_vec;
      a1   = int'(hif.id_rs1);
      a2   = int'(hif.id_rs2);
      live = hif.id_valid && !hif.flush && !m_kill;
      es = 1'b0; eb = 1'b0; eh = 1'b0;
      if (m_busy > 0) begin
        es = 1'b1; eh = 1'b1;
      end else if (hif.flush || m_kill) begin
        eb = 1'b1;
      end else if (live && m_ex.ld && (hits(m_ex, a1, hif.id_use1, vec) || hits(m_ex, a2, hif.id_use2, vec))) begin
        es = 1'b1; eb = 1'b1;
      end
      exp = {es, eb, eh, m_fa, m_fb, m_fva, m_fvb};
    end
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL model t=%0t: got {stall,bubble,hold,fa,fb,fva,fvb}=%b required %b", $time, got, exp);
    end
    if (!rst) begin
      if (eh) begin
        m_mem = '0;
        m_busy--;
        if (hif.flush) m_kill = 1'b1;
      end else begin
        iss = live && !eb;
        m_fa  = (iss && !vec) ? pick(hits(m_ex, a1, hif.id_use1, vec), hits(m_mem, a1, hif.id_use1, vec)) : 2'd0;
        m_fb  = (iss && !vec) ? pick(hits(m_ex, a2, hif.id_use2, vec), hits(m_mem, a2, hif.id_use2, vec)) : 2'd0;
        m_fva = (iss &&  vec) ? pick(hits(m_ex, a1, hif.id_use1, vec), hits(m_mem, a1, hif.id_use1, vec)) : 2'd0;
        m_fvb = (iss &&  vec) ? pick(hits(m_ex, a2, hif.id_use2, vec), hits(m_mem, a2, hif.id_use2, vec)) : 2'd0;
        cur = '{v: 1'b1, rd: 8'(hif.id_rd), we: hif.id_we, vec: vec, ld: hif.id_load};
        m_kill = 1'b0;
        m_mem  = m_ex;
        m_ex   = iss ? cur : '0;
        if (iss && hif.id_multi) m_busy = VOP_CYCLES - 1;
      end
    end
  end

  task automatic put(bit v, int rs1, int rs2, bit u1, bit u2, int rd,
                     bit we, bit vec, bit ld, bit mul, bit fl);
    hif.id_valid = v;
    hif.id_rs1   = REG_AW'(rs1);
    hif.id_rs2   = REG_AW'(rs2);
    hif.id_use1  = u1;
    hif.id_use2  = u2;
    hif.id_rd    = REG_AW'(rd);
    hif.id_we    = we;
    hif.id_vec   = vec;
    hif.id_load  = ld;
    hif.id_multi = mul;
    hif.flush    = fl;
  endtask

  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) nxt();
  endtask

  task automatic lit(string nm, int act, int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int holds;
    nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("reset stall", hif.stall, 0);
    lit("reset fwd_a", hif.fwd_a, 0);
    nxt();
    rst = 1'b0;
    drain();

    // EX producer forwards 01; r0 never forwards
    put(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); nxt();
    put(1, 3, 0, 1, 0, 9, 1, 0, 0, 0, 0); @(negedge clk);
    lit("exfwd stall", hif.stall, 0); nxt();
    nop(); @(negedge clk);
    lit("exfwd fwd_a", hif.fwd_a, 1); nxt();
    drain();
    put(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); nxt();
    put(1, 0, 0, 1, 0, 9, 1, 0, 0, 0, 0); nxt();
    nop(); @(negedge clk);
    lit("r0 fwd_a", hif.fwd_a, 0); nxt();
    drain();

    // younger EX beats MEM; MEM alone gives 10
    put(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); nxt();
    put(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); nxt();
    put(1, 0, 5, 0, 1, 9, 1, 0, 0, 0, 0); nxt();
    nop(); @(negedge clk);
    lit("prio fwd_b", hif.fwd_b, 1); nxt();
    drain();
    put(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); nxt();
    nop(); nxt();
    put(1, 0, 5, 0, 1, 9, 1, 0, 0, 0, 0); nxt();
    nop(); @(negedge clk);
    lit("mem fwd_b", hif.fwd_b, 2); nxt();
    drain();

    // load-use: one stall cycle then MEM/WB forward; flush suppresses stall
    put(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0); nxt();
    put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0, 0); @(negedge clk);
    lit("lu stall", hif.stall, 1);
    lit("lu bubble", hif.bubble, 1); nxt();
    @(negedge clk);
    lit("lu stall2", hif.stall, 0);
    lit("lu bubble2", hif.bubble, 0); nxt();
    nop(); @(negedge clk);
    lit("lu fwd_a", hif.fwd_a, 2); nxt();
    drain();
    put(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0); nxt();
    put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0, 1); @(negedge clk);
    lit("luflush stall", hif.stall, 0);
    lit("luflush bubble", hif.bubble, 1); nxt();
    nop(); @(negedge clk);
    lit("luflush fwd_a", hif.fwd_a, 0); nxt();
    drain();

    // file mismatch; v0 is a real register; id_valid=0 never forwards
    put(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0); nxt();
    put(1, 2, 0, 1, 0, 4, 1, 0, 0, 0, 0); nxt();
    nop(); @(negedge clk);
    lit("xfile fwd_a", hif.fwd_a, 0); nxt();
    drain();
    put(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); nxt();
    put(1, 0, 0, 1, 0, 5, 1, 1, 0, 0, 0); nxt();
    nop(); @(negedge clk);
    lit("v0 fwdv_a", hif.fwdv_a, 1); nxt();
    drain();
    put(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); nxt();
    put(0, 3, 0, 1, 0, 9, 1, 0, 0, 0, 0); nxt();
    nop(); @(negedge clk);
    lit("novalid fwd_a", hif.fwd_a, 0); nxt();
    drain();

    // multi-cycle vector op: 3 hold cycles, selects frozen
    put(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0); nxt();
    put(1, 2, 0, 1, 0, 1, 1, 1, 0, 1, 0); @(negedge clk);
    lit("vop entry stall", hif.stall, 0); nxt();
    put(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0);
    holds = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      holds += int'(hif.ex_hold);
      lit("vop fwdv_a frozen", hif.fwdv_a, 1);
      nxt();
    end
    lit("vop hold cycles", holds, 3);
    nop(); @(negedge clk);
    lit("vop dep fwdv_a", hif.fwdv_a, 1); nxt();
    drain();

    // flush during VBUSY: hold unchanged, killed instruction bubbled on exit
    put(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0); nxt();
    put(1, 2, 0, 1, 0, 1, 1, 1, 0, 1, 0); nxt();
    put(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 1);
    @(negedge clk);
    holds = int'(hif.ex_hold);
    nxt();
    put(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      holds += int'(hif.ex_hold);
      if (i == 3) lit("vflush exit bubble", hif.bubble, 1);
      nxt();
    end
    lit("vflush hold cycles", holds, 3);
    @(negedge clk);
    lit("vflush killed fwdv_a", hif.fwdv_a, 0); nxt();
    drain();

    // back-to-back multi ops: single non-hold cycle between
    put(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0); nxt();
    put(1, 0, 0, 0, 0, 4, 1, 1, 0, 1, 0);
    holds = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      holds += int'(hif.ex_hold);
      if (i == 3) lit("b2b gap hold", hif.ex_hold, 0);
      nxt();
      if (i == 3) nop();
    end
    lit("b2b hold cycles", holds, 6);
    drain();

    // reset in the middle of VBUSY
    put(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0); nxt();
    nop(); nxt();
    rst = 1'b1;
    @(negedge clk);
    lit("rst hold", hif.ex_hold, 0);
    lit("rst stall", hif.stall, 0); nxt();
    rst = 1'b0;
    @(negedge clk);
    lit("post-rst stall", hif.stall, 0);
    lit("post-rst hold", hif.ex_hold, 0); nxt();
    @(negedge clk);
    lit("post-rst hold2", hif.ex_hold, 0); nxt();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
